mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, fixed-latency memory between the fetch stage (read-only instruction port) and the memory stage (load/store port). The arbiter latches a granted request, runs a LATENCY-cycle memory transaction, and pulses a per-port ready. It also generates StallF_o and StallM_o so the hazard logic holds the PC and the memory stage until their access completes. It sits between fetch/memory stages and the unified memory model, and replaces direct instrmem reads.

## Interface
- DATA_WIDTH, 32: address and data width.
- LATENCY, 2: cycles each memory transaction occupies, ≥1; counter width $clog2(LATENCY+1).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- IReq_i  in  1  fetch read request; held until IReady_o.
- IAddr_i  in  DATA_WIDTH  fetch address; stable while IReq_i high.
- IRdata_o  out  DATA_WIDTH  instruction; MemRdata_i when IReady_o, else 0.
- IReady_o  out  1  one-cycle pulse, fetch access complete.
- DReq_i  in  1  data request; held until DReady_o.
- DWe_i  in  1  1 = write, 0 = read.
- DAddr_i, DWdata_i  in  DATA_WIDTH  data address / write data.
- DByteEn_i  in  4  write byte enables.
- DRdata_o  out  DATA_WIDTH  MemRdata_i when DReady_o and latched we = 0, else 0.
- DReady_o  out  1  one-cycle pulse, data access complete.
- StallF_o, StallM_o  out  1  IReq_i & ~IReady_o / DReq_i & ~DReady_o.
- MemReq_o, MemWe_o  out  1  memory strobe / write enable, held for whole transaction.
- MemAddr_o, MemWdata_o  out  DATA_WIDTH  latched address / write data.
- MemByteEn_o  out  4  latched byte enables (0 for fetch).
- MemRdata_i  in  DATA_WIDTH  memory read data, valid in final transaction cycle.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registered owner, cnt, latched addr/wdata/we/be.
- IDLE: no requests → stay. One request → grant it. Both → grant per priority (see Configuration). On grant edge, latch requester's fields, cnt ← LATENCY-1, go BUSY_x.
- BUSY_x: MemReq_o = 1, Mem* outputs from latches; fetch grants drive MemWe_o = 0 and MemByteEn_o = 0. Each cycle with cnt ≠ 0, cnt decrements.
- Completion cycle is cnt = 0: xReady_o = 1 (combinational from state and cnt), and read data is passed through.
- On the completion edge:
  - Other requester's Req high → grant it directly; latch its fields; cnt ← LATENCY-1.
  - Otherwise → IDLE.
- The just-served requester is never re-granted on its completion edge; its address is updating. It is re-arbitrated from IDLE one cycle later.
- Req dropped mid-transaction: the transaction still runs to completion, including writes; the Ready pulse is still issued and ignored.
- Req inputs are ignored while BUSY except at the completion-edge handoff.

## Timing
- Reset: state IDLE, cnt 0, all latches 0. All outputs 0 except StallF_o/StallM_o, which follow Req inputs combinationally.
- Grant to Ready: the Ready pulse falls in the LATENCY-th cycle after the grant edge. Single-request latency from Req rise is LATENCY+1 cycles including the IDLE sample cycle.
- Back-to-back handoff: no idle cycle between transactions of different owners.
- Same requester repeated: one IDLE bubble between transactions.
- Async reset mid-transaction: immediately IDLE, MemReq_o and Ready drop. The partial write is abandoned; the memory model ignores unfinished strobes.
- LATENCY = 1: every BUSY cycle is a completion cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a last-owner flag (reset = data) is updated at each grant. When both Reqs are seen in IDLE, the port not last served is granted.
- Undefined: when both Reqs are seen in IDLE, data wins (fixed priority).
- The handoff rule applies in both builds.

## Test plan
- Reset, then IReq_i = 1, IAddr_i = 0xBFC00000, memory returns 0x00500093. Required: MemAddr_o = 0xBFC00000 for 2 cycles, then IReady_o pulse with IRdata_o = 0x00500093 in cycle 3, StallF_o high in cycles 1–2.
- Data write DAddr_i = 0x100, DWdata_i = 0xDEADBEEF, DByteEn_i = 0xF. Required: MemWe_o = 1 for 2 cycles, DReady_o pulse, DRdata_o = 0.
- IReq_i and DReq_i rise together, without the macro. Required: data served first, fetch granted on the data completion edge with no gap, IReady_o exactly 2 cycles after DReady_o.
- Same as above with ARB_ROUND_ROBIN_EN and last owner = data. Required: fetch granted first.
- IReq_i held high across 2 fetches (0x0 then 0x4). Required: one IDLE cycle between transactions, second MemAddr_o = 0x4.
- rst asserted mid-BUSY_D. Required: the same cycle, MemReq_o = 0, DReady_o = 0, state IDLE, and no Ready pulse after release until a new grant.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the shared memory port.
// slave is the arbiter's view; master is the view of the pipeline/memory around it.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  IReq_i;
    logic [DATA_WIDTH-1:0] IAddr_i;
    logic [DATA_WIDTH-1:0] IRdata_o;
    logic                  IReady_o;

    logic                  DReq_i;
    logic                  DWe_i;
    logic [DATA_WIDTH-1:0] DAddr_i;
    logic [DATA_WIDTH-1:0] DWdata_i;
    logic [3:0]            DByteEn_i;
    logic [DATA_WIDTH-1:0] DRdata_o;
    logic                  DReady_o;

    logic                  StallF_o;
    logic                  StallM_o;

    logic                  MemReq_o;
    logic                  MemWe_o;
    logic [DATA_WIDTH-1:0] MemAddr_o;
    logic [DATA_WIDTH-1:0] MemWdata_o;
    logic [3:0]            MemByteEn_o;
    logic [DATA_WIDTH-1:0] MemRdata_i;

    modport slave (
        input  IReq_i, IAddr_i, DReq_i, DWe_i, DAddr_i, DWdata_i, DByteEn_i, MemRdata_i,
        output IRdata_o, IReady_o, DRdata_o, DReady_o, StallF_o, StallM_o,
               MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o
    );

    modport master (
        output IReq_i, IAddr_i, DReq_i, DWe_i, DAddr_i, DWdata_i, DByteEn_i, MemRdata_i,
        input  IRdata_o, IReady_o, DRdata_o, DReady_o, StallF_o, StallM_o,
               MemReq_o, MemWe_o, MemAddr_o, MemWdata_o, MemByteEn_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between the fetch and load/store ports.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-first priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int            CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_we;
    logic [3:0]            lat_be;
    logic                  busy;
    logic                  done;
    logic                  grant_i;
    logic                  grant_d;
    logic                  pick_d;

    assign busy = (state != IDLE);
    assign done = busy && (cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
    // Tie-break favours whichever port was not granted most recently.
    logic last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (grant_i || grant_d) begin
            last_d <= grant_d;
        end
    end

    assign pick_d = ~last_d;
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                cnt       <= CNT_LOAD;
                lat_addr  <= bus.DAddr_i;
                lat_wdata <= bus.DWdata_i;
                lat_we    <= bus.DWe_i;
                lat_be    <= bus.DByteEn_i;
            end else if (grant_i) begin
                cnt       <= CNT_LOAD;
                lat_addr  <= bus.IAddr_i;
                lat_wdata <= '0;
                lat_we    <= 1'b0;
                lat_be    <= '0;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // On completion only the other port may be handed the memory; the
    // just-served port must pass through IDLE so its new address is seen.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.IReq_i && bus.DReq_i) begin
                    grant_d = pick_d;
                    grant_i = ~pick_d;
                end else if (bus.DReq_i) begin
                    grant_d = 1'b1;
                end else if (bus.IReq_i) begin
                    grant_i = 1'b1;
                end
            end
            BUSY_I: begin
                if (done) begin
                    if (bus.DReq_i) grant_d = 1'b1;
                    else            next_state = IDLE;
                end
            end
            BUSY_D: begin
                if (done) begin
                    if (bus.IReq_i) grant_i = 1'b1;
                    else            next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (grant_i)      next_state = BUSY_I;
        else if (grant_d) next_state = BUSY_D;
    end

    always_comb begin
        bus.MemReq_o    = busy;
        bus.MemWe_o     = busy & lat_we;
        bus.MemAddr_o   = busy ? lat_addr  : '0;
        bus.MemWdata_o  = busy ? lat_wdata : '0;
        bus.MemByteEn_o = busy ? lat_be    : '0;
        bus.IReady_o    = (state == BUSY_I) && done;
        bus.DReady_o    = (state == BUSY_D) && done;
        bus.IRdata_o    = bus.IReady_o ? bus.MemRdata_i : '0;
        bus.DRdata_o    = (bus.DReady_o && !lat_we) ? bus.MemRdata_i : '0;
        bus.StallF_o    = bus.IReq_i & ~bus.IReady_o;
        bus.StallM_o    = bus.DReq_i & ~bus.DReady_o;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an edge-indexed transaction model checked every cycle,
// plus hand-computed expectations for the fetch, write, tie-break, bubble and reset cases.
module tb_mem_arbiter;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
    endfunction

    assign bus.MemRdata_i = mem_word(bus.MemAddr_o);

    // Model: a transaction granted at edge n owns the memory until edge n+LAT,
    // and its ready falls in the cycle just before that edge.
    int          edge_n   = 0;
    bit          m_busy   = 1'b0;
    bit          m_own_d  = 1'b0;
    int          m_end    = 0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    bit          m_we     = 1'b0;
    logic [3:0]  m_be     = '0;
    bit          m_last_d = 1'b1;

    task automatic modelGrant(input bit to_d);
        m_busy   = 1'b1;
        m_own_d  = to_d;
        m_end    = edge_n + LAT;
        m_last_d = to_d;
        if (to_d) begin
            m_addr  = bus.DAddr_i;
            m_wdata = bus.DWdata_i;
            m_we    = bus.DWe_i;
            m_be    = bus.DByteEn_i;
        end else begin
            m_addr  = bus.IAddr_i;
            m_wdata = '0;
            m_we    = 1'b0;
            m_be    = '0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   = 1'b0;
            m_last_d = 1'b1;
            edge_n   = 0;
        end else begin
            edge_n++;
            if (m_busy) begin
                if (edge_n == m_end) begin
                    if (m_own_d && bus.IReq_i)       modelGrant(1'b0);
                    else if (!m_own_d && bus.DReq_i) modelGrant(1'b1);
                    else                             m_busy = 1'b0;
                end
            end else if (bus.IReq_i && bus.DReq_i) begin
                modelGrant(RR ? !m_last_d : 1'b1);
            end else if (bus.IReq_i || bus.DReq_i) begin
                modelGrant(bus.DReq_i);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit ri;
        bit rd;
        ri = m_busy && !m_own_d && (edge_n == m_end - 1);
        rd = m_busy &&  m_own_d && (edge_n == m_end - 1);
        checkOutput("m_MemReq",  32'(bus.MemReq_o), 32'(m_busy));
        checkOutput("m_IReady",  32'(bus.IReady_o), 32'(ri));
        checkOutput("m_DReady",  32'(bus.DReady_o), 32'(rd));
        checkOutput("m_IRdata",  bus.IRdata_o, ri ? mem_word(m_addr) : 32'h0);
        checkOutput("m_DRdata",  bus.DRdata_o, (rd && !m_we) ? mem_word(m_addr) : 32'h0);
        checkOutput("m_StallF",  32'(bus.StallF_o), 32'(bus.IReq_i && !ri));
        checkOutput("m_StallM",  32'(bus.StallM_o), 32'(bus.DReq_i && !rd));
        if (m_busy) begin
            checkOutput("m_MemAddr", bus.MemAddr_o, m_addr);
            checkOutput("m_MemWe",   32'(bus.MemWe_o), 32'(m_we));
            checkOutput("m_MemBe",   32'(bus.MemByteEn_o), 32'(m_be));
            if (m_own_d) checkOutput("m_MemWdata", bus.MemWdata_o, m_wdata);
        end
    end

    task automatic applyStimulus(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                                 input bit dwe, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input logic [3:0] dbe);
        bus.IReq_i    = ireq;
        bus.IAddr_i   = iaddr;
        bus.DReq_i    = dreq;
        bus.DWe_i     = dwe;
        bus.DAddr_i   = daddr;
        bus.DWdata_i  = dwdata;
        bus.DByteEn_i = dbe;
    endtask

    // Counts negedges until the chosen ready is seen; an exhausted budget is a failure.
    task automatic waitReady(input bit want_d, input int budget, output int took);
        took = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (want_d ? bus.DReady_o : bus.IReady_o) begin
                took = i;
                break;
            end
        end
        if (took < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ready_%s: got timeout expected ready within %0d cycles",
                     want_d ? "d" : "i", budget);
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got no end of stimulus expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int  t;
        bit  first_d;
        first_d = !RR;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("rst_MemReq",  32'(bus.MemReq_o), 32'h0);
        checkOutput("rst_MemAddr", bus.MemAddr_o, 32'h0);
        checkOutput("rst_IReady",  32'(bus.IReady_o), 32'h0);
        checkOutput("rst_DReady",  32'(bus.DReady_o), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        $display("[TB] single fetch");
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("f1_StallF", 32'(bus.StallF_o), 32'h1);
        checkOutput("f1_MemReq", 32'(bus.MemReq_o), 32'h0);
        @(negedge clk);
        checkOutput("f2_MemAddr", bus.MemAddr_o, 32'hBFC0_0000);
        checkOutput("f2_IReady",  32'(bus.IReady_o), 32'h0);
        checkOutput("f2_StallF",  32'(bus.StallF_o), 32'h1);
        @(negedge clk);
        checkOutput("f3_MemAddr", bus.MemAddr_o, 32'hBFC0_0000);
        checkOutput("f3_IReady",  32'(bus.IReady_o), 32'h1);
        checkOutput("f3_IRdata",  bus.IRdata_o, 32'h0050_0093);
        checkOutput("f3_StallF",  32'(bus.StallF_o), 32'h0);
        @(posedge clk); #1 applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] data write");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        checkOutput("w1_StallM", 32'(bus.StallM_o), 32'h1);
        @(negedge clk);
        checkOutput("w2_MemWe",    32'(bus.MemWe_o), 32'h1);
        checkOutput("w2_MemWdata", bus.MemWdata_o, 32'hDEAD_BEEF);
        checkOutput("w2_MemBe",    32'(bus.MemByteEn_o), 32'hF);
        checkOutput("w2_DReady",   32'(bus.DReady_o), 32'h0);
        @(negedge clk);
        checkOutput("w3_MemWe",  32'(bus.MemWe_o), 32'h1);
        checkOutput("w3_DReady", 32'(bus.DReady_o), 32'h1);
        checkOutput("w3_DRdata", bus.DRdata_o, 32'h0);
        @(posedge clk); #1 applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] simultaneous requests, first served %s", first_d ? "data" : "fetch");
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, '0, '0);
        waitReady(first_d, 6, t);
        checkOutput("both_first_latency", 32'(t), 32'd2);
        checkOutput("both_other_idle", 32'(first_d ? bus.IReady_o : bus.DReady_o), 32'h0);
        @(posedge clk); #1;
        if (first_d) bus.DReq_i = 1'b0;
        else         bus.IReq_i = 1'b0;
        @(negedge clk);
        checkOutput("both_nogap_MemReq", 32'(bus.MemReq_o), 32'h1);
        checkOutput("both_second_addr",  bus.MemAddr_o, first_d ? 32'h10 : 32'h200);
        waitReady(!first_d, 4, t);
        checkOutput("both_second_gap", 32'(t), 32'd0);
        @(posedge clk); #1 applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] fetch held across two accesses");
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, '0);
        waitReady(1'b0, 6, t);
        checkOutput("rep_first_latency", 32'(t), 32'd2);
        @(posedge clk); #1 bus.IAddr_i = 32'h4;
        @(negedge clk);
        checkOutput("rep_bubble_MemReq", 32'(bus.MemReq_o), 32'h0);
        @(negedge clk);
        checkOutput("rep_second_MemAddr", bus.MemAddr_o, 32'h4);
        waitReady(1'b0, 4, t);
        checkOutput("rep_second_latency", 32'(t), 32'd0);
        @(posedge clk); #1 applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] data request arriving during a fetch");
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(posedge clk); #1 applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, '0, '0);
        waitReady(1'b0, 4, t);
        checkOutput("late_fetch_latency", 32'(t), 32'd1);
        @(posedge clk); #1 bus.IReq_i = 1'b0;
        waitReady(1'b1, 4, t);
        checkOutput("late_data_gap", 32'(t), 32'd1);
        checkOutput("late_DRdata", bus.DRdata_o, 32'h0080_FF7F);
        @(posedge clk); #1 applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] reset during a data write");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 4'h3);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ar_busy_MemReq", 32'(bus.MemReq_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar_MemReq", 32'(bus.MemReq_o), 32'h0);
        checkOutput("ar_DReady", 32'(bus.DReady_o), 32'h0);
        checkOutput("ar_StallM", 32'(bus.StallM_o), 32'h1);
        @(posedge clk); #1 applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("ar_after_DReady", 32'(bus.DReady_o), 32'h0);
            checkOutput("ar_after_MemReq", 32'(bus.MemReq_o), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
